reg_bank_p: RTL and testbench
=============================

# reg_bank_p

Parametrised successor to the board-level register bank between the UART command ports and the ALU. It holds NREGS words of DW bits and supports full, half-lane and accumulate writes. Two independently registered read ports each have a constant-injection option and same-cycle write bypass. A sequential clear sweep runs automatically after reset and on request, signalled by a busy flag that the command interpreter reads back on an input port.

## Interface
Parameters:
- DW, 64, data width; must be even.
- NREGS, 16, register count; power of two, at least 2. AW = $clog2(NREGS).
- CONSTA, 1, value loaded on port A when cnstA is set; zero-extended to DW.
- CONSTB, 0, value loaded on port B when cnstB is set; zero-extended to DW.

Ports:
- clock  in  1  master clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- inA  in  DW  write data.
- wen  in  1  write strobe.
- selwreg  in  AW  write address.
- wmode  in  2  write mode: 00 full, 01 low half, 10 high half, 11 accumulate.
- seloutA  in  AW  read address, port A.
- cnstA  in  1  load CONSTA instead of register data, port A.
- enrregA  in  1  output-register enable, port A.
- outA  out  DW  registered read data, port A.
- seloutB, cnstB, enrregB, outB: as for port A, applied to port B.
- clr  in  1  request a clear sweep.
- busy  out  1  clear sweep in progress.

## Operation
- Storage is an inferred distributed RAM of NREGS×DW. Contents are not reset directly; they are zeroed by the sweep.
- Write, when wen=1 and state=IDLE, at the clock edge:
  - Full: reg = inA.
  - Low half: reg[DW/2-1:0] = inA[DW/2-1:0]; upper half kept.
  - High half: reg[DW-1:DW/2] = inA[DW/2-1:0]; lower half kept.
  - Accumulate: reg = reg + inA, modulo 2^DW; carry discarded.
- Read, port A (port B identical), when enrregA=1:
  - outA = CONSTA if cnstA=1.
  - Otherwise, if a write is accepted this cycle and selwreg == seloutA, outA = the merged new value (bypass).
  - Otherwise outA = reg[seloutA].
  - When enrregA=0, outA holds.
- FSM states: IDLE and CLEAR.
  - Reset puts the FSM in CLEAR with ptr=0.
  - In IDLE, clr=1 moves to CLEAR with ptr=0.
  - In CLEAR, each cycle writes reg[ptr]=0 and increments ptr. After writing ptr==NREGS-1, the FSM returns to IDLE.
  - busy = (state==CLEAR).
- While busy:
  - wen is ignored; no write occurs.
  - clr is ignored.
  - An enabled read loads CONSTx if cnstx=1, otherwise 0.
- If wen and clr arrive together in IDLE, the write is performed and the sweep then clears it.
- Two ports addressing the same register read identical data. Bypass applies to both ports.

## Timing
- Reset values: outA=0, outB=0, busy=1, ptr=0, state=CLEAR.
- busy stays 1 for exactly NREGS cycles after the first clock edge at which reset=0. On the following edge it reads 0.
- A clr sampled in IDLE raises busy at the next edge. busy then stays 1 for exactly NREGS cycles.
- Read latency is 1 cycle: outputs change only on a clock edge with enrreg set.
- A write accepted at edge N is visible through a non-bypass read enabled at edge N+1, with outx updated at N+1.
- Accumulating twice into the same register on consecutive cycles sees the first result; there is no hazard.
- Reset asserted mid-sweep restarts the sweep at ptr=0.

## Structure
- Shared package reg_bank_pkg holds:
  - the wmode codes WM_FULL, WM_LO, WM_HI, WM_ACC;
  - the state encoding ST_IDLE, ST_CLEAR.
- Sub-module reg_bank_merge, combinational: (old, inA, wmode) → new word. It is used once for the RAM write and reused for both bypass paths.
- Top-level wiring maps inA to an output port (P0out), busy to the P7in bit that previously carried busy, and outA/outB to the ALU operands.

## Test plan
Every scenario uses DW=64, NREGS=16, CONSTA=1, CONSTB=0.
- Release reset → busy=1 for 16 cycles then 0. Reading each of r0..r15 on both ports returns 0.
- Full write r3=0x0123_4567_89AB_CDEF, then low-half write r3 with inA=0xFFFF_FFFF → read r3 = 0x0123_4567_FFFF_FFFF. Then high-half write with inA=0x0 → read r3 = 0x0000_0000_FFFF_FFFF.
- r5=0xFFFF_FFFF_FFFF_FFFF, then accumulate with inA=2 → r5 reads 1 (wrap). A second accumulate with inA=3 on the next cycle → r5 reads 4.
- Write r7=0xAA with seloutA=7, enrregA=1 in the same cycle → outA=0xAA at that edge (bypass). Same cycle with cnstB=1, enrregB=1 → outB=0.
- clr pulse while r2=0x55 → busy for 16 cycles. A wen to r9 at sweep cycle 4 is ignored; a second clr at sweep cycle 8 is ignored. After the sweep, r2=0 and r9=0.
- Assert reset for 1 cycle at sweep cycle 10 → outA=outB=0. busy then runs a fresh 16 cycles after release.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared write-mode codes and sweep FSM encoding for the register bank.
package reg_bank_pkg;

    localparam logic [1:0] WM_FULL = 2'b00;
    localparam logic [1:0] WM_LO   = 2'b01;
    localparam logic [1:0] WM_HI   = 2'b10;
    localparam logic [1:0] WM_ACC  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_merge.sv
// Combinational word merge: builds the value a write would leave in a register.
// Zero latency; no flow control.
module reg_bank_merge
    import reg_bank_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [DW-1:0] i_old,
    input  logic [DW-1:0] i_din,
    input  logic [1:0]    i_wmode,
    output logic [DW-1:0] o_new
);

    localparam int HW = DW / 2;

    always_comb begin
        o_new = i_din;
        case (i_wmode)
            WM_FULL: o_new = i_din;
            WM_LO:   o_new = {i_old[DW-1:HW], i_din[HW-1:0]};
            // High-half writes take their data from the low lane of inA.
            WM_HI:   o_new = {i_din[HW-1:0], i_old[HW-1:0]};
            WM_ACC:  o_new = i_old + i_din;
            default: o_new = i_din;
        endcase
    end

endmodule

// File: rtl/reg_bank_p.sv
// NREGS x DW register bank, two registered read ports with bypass, self-clearing sweep.
// Read latency 1 cycle; writes are dropped (no backpressure) while busy.
module reg_bank_p
    import reg_bank_pkg::*;
#(
    parameter int            DW     = 64,
    parameter int            NREGS  = 16,
    parameter logic [DW-1:0] CONSTA = DW'(1),
    parameter logic [DW-1:0] CONSTB = '0,
    localparam int           AW     = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] inA,
    input  logic          wen,
    input  logic [AW-1:0] selwreg,
    input  logic [1:0]    wmode,
    input  logic [AW-1:0] seloutA,
    input  logic          cnstA,
    input  logic          enrregA,
    output logic [DW-1:0] outA,
    input  logic [AW-1:0] seloutB,
    input  logic          cnstB,
    input  logic          enrregB,
    output logic [DW-1:0] outB,
    input  logic          clr,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          w_busy;
    logic          w_wr_acc;
    logic [DW-1:0] r_mem [NREGS];
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_new;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;
    logic [DW-1:0] r_out_a;
    logic [DW-1:0] r_out_b;

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_wr_acc = wen && !w_busy;
    assign w_old    = r_mem[selwreg];

    // One merge feeds both the RAM write and the bypass on each read port.
    reg_bank_merge #(.DW(DW)) u_merge (
        .i_old   (w_old),
        .i_din   (inA),
        .i_wmode (wmode),
        .o_new   (w_new)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + AW'(1);
                if (r_ptr == AW'(NREGS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Storage has no reset of its own; the sweep zeroes it one word per cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_busy) begin
                r_mem[r_ptr] <= '0;
            end else if (wen) begin
                r_mem[selwreg] <= w_new;
            end
        end
    end

    always_comb begin
        w_rd_a = r_mem[seloutA];
        if (cnstA) begin
            w_rd_a = CONSTA;
        end else if (w_busy) begin
            w_rd_a = '0;
        end else if (w_wr_acc && (selwreg == seloutA)) begin
            w_rd_a = w_new;
        end
    end

    always_comb begin
        w_rd_b = r_mem[seloutB];
        if (cnstB) begin
            w_rd_b = CONSTB;
        end else if (w_busy) begin
            w_rd_b = '0;
        end else if (w_wr_acc && (selwreg == seloutB)) begin
            w_rd_b = w_new;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_a <= '0;
            r_out_b <= '0;
        end else begin
            if (enrregA) r_out_a <= w_rd_a;
            if (enrregB) r_out_b <= w_rd_b;
        end
    end

    assign outA = r_out_a;
    assign outB = r_out_b;
    assign busy = w_busy;

endmodule

// File: tb/tb_reg_bank_p.sv
// Self-checking bench for reg_bank_p: directed scenarios plus randomized traffic vs a word-level model.
module tb_reg_bank_p;

    localparam int            DW    = 64;
    localparam int            NREGS = 16;
    localparam int            AW    = 4;
    localparam logic [DW-1:0] CA    = 64'd1;
    localparam logic [DW-1:0] CB    = 64'd0;
    localparam logic [1:0]    M_FULL = 2'b00;
    localparam logic [1:0]    M_LO   = 2'b01;
    localparam logic [1:0]    M_HI   = 2'b10;
    localparam logic [1:0]    M_ACC  = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] inA;
    logic          wen;
    logic [AW-1:0] selwreg;
    logic [1:0]    wmode;
    logic [AW-1:0] seloutA;
    logic          cnstA;
    logic          enrregA;
    logic [DW-1:0] outA;
    logic [AW-1:0] seloutB;
    logic          cnstB;
    logic          enrregB;
    logic [DW-1:0] outB;
    logic          clr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents, remaining sweep cycles, output registers.
    logic [DW-1:0] m_mem [NREGS];
    int            m_busy_cnt;
    logic [DW-1:0] m_outA;
    logic [DW-1:0] m_outB;

    always #5 clock = ~clock;

    reg_bank_p #(
        .DW     (DW),
        .NREGS  (NREGS),
        .CONSTA (CA),
        .CONSTB (CB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inA     (inA),
        .wen     (wen),
        .selwreg (selwreg),
        .wmode   (wmode),
        .seloutA (seloutA),
        .cnstA   (cnstA),
        .enrregA (enrregA),
        .outA    (outA),
        .seloutB (seloutB),
        .cnstB   (cnstB),
        .enrregB (enrregB),
        .outB    (outB),
        .clr     (clr),
        .busy    (busy)
    );

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                              input logic [1:0] m);
        case (m)
            M_FULL:  return d;
            M_LO:    return {old[63:32], d[31:0]};
            M_HI:    return {d[31:0], old[31:0]};
            default: return old + d;
        endcase
    endfunction

    task automatic idle_inputs();
        inA = '0; wen = 1'b0; selwreg = '0; wmode = M_FULL;
        seloutA = '0; cnstA = 1'b0; enrregA = 1'b0;
        seloutB = '0; cnstB = 1'b0; enrregB = 1'b0;
        clr = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [DW-1:0] nv;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
            m_busy_cnt = NREGS;
            m_outA = '0;
            m_outB = '0;
        end else if (m_busy_cnt > 0) begin
            if (enrregA) m_outA = cnstA ? CA : '0;
            if (enrregB) m_outB = cnstB ? CB : '0;
            m_busy_cnt--;
        end else begin
            nv = f_merge(m_mem[selwreg], inA, wmode);
            if (enrregA) m_outA = cnstA ? CA : ((wen && selwreg == seloutA) ? nv : m_mem[seloutA]);
            if (enrregB) m_outB = cnstB ? CB : ((wen && selwreg == seloutB) ? nv : m_mem[seloutB]);
            if (wen) m_mem[selwreg] = nv;
            if (clr) begin
                for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
                m_busy_cnt = NREGS;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [1:0] m);
        idle_inputs();
        wen = 1'b1; selwreg = AW'(a); inA = d; wmode = m;
        tick();
    endtask

    task automatic do_read(input int a);
        idle_inputs();
        seloutA = AW'(a); seloutB = AW'(a);
        enrregA = 1'b1; enrregB = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (outA !== 64'd0 || outB !== 64'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: outA=%h outB=%h busy=%b, want 0 0 1", outA, outB, busy);
        end
    endtask

    task automatic test_sweep_after_reset();
        int n;
        n = 0;
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n = k;
            if (busy !== 1'b1) break;
        end
        n_checks++;
        if (n != NREGS) begin
            n_fail++;
            $display("FAIL reset_sweep_len: busy dropped after %0d edges, want %0d", n, NREGS);
        end
        for (int r = 0; r < NREGS; r++) begin
            do_read(r);
            n_checks++;
            if (outA !== 64'd0 || outB !== 64'd0) begin
                n_fail++;
                $display("FAIL cleared_r%0d: outA=%h outB=%h, want 0", r, outA, outB);
            end
        end
    endtask

    task automatic test_half_writes();
        do_write(3, 64'h0123_4567_89AB_CDEF, M_FULL);
        do_write(3, 64'h0000_0000_FFFF_FFFF, M_LO);
        do_read(3);
        n_checks++;
        if (outA !== 64'h0123_4567_FFFF_FFFF || outB !== 64'h0123_4567_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL low_half: outA=%h outB=%h, want 01234567ffffffff", outA, outB);
        end
        do_write(3, 64'h0, M_HI);
        do_read(3);
        n_checks++;
        if (outA !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL high_half: outA=%h, want 00000000ffffffff", outA);
        end
    endtask

    task automatic test_accumulate();
        do_write(5, 64'hFFFF_FFFF_FFFF_FFFF, M_FULL);
        idle_inputs();
        wen = 1'b1; selwreg = 4'd5; wmode = M_ACC; inA = 64'd2;
        seloutA = 4'd5; enrregA = 1'b1;
        tick();
        n_checks++;
        if (outA !== 64'd1) begin
            n_fail++;
            $display("FAIL acc_wrap: outA=%h, want 1", outA);
        end
        inA = 64'd3;
        tick();
        n_checks++;
        if (outA !== 64'd4) begin
            n_fail++;
            $display("FAIL acc_back_to_back: outA=%h, want 4", outA);
        end
        do_read(5);
        n_checks++;
        if (outA !== 64'd4 || outB !== 64'd4) begin
            n_fail++;
            $display("FAIL acc_readback: outA=%h outB=%h, want 4", outA, outB);
        end
    endtask

    task automatic test_bypass();
        do_read(3);
        idle_inputs();
        wen = 1'b1; selwreg = 4'd7; wmode = M_FULL; inA = 64'hAA;
        seloutA = 4'd7; enrregA = 1'b1;
        seloutB = 4'd7; enrregB = 1'b1; cnstB = 1'b1;
        tick();
        n_checks++;
        if (outA !== 64'hAA || outB !== 64'd0) begin
            n_fail++;
            $display("FAIL bypass: outA=%h outB=%h, want aa 0", outA, outB);
        end
        idle_inputs();
        cnstA = 1'b1; enrregA = 1'b1;
        tick();
        n_checks++;
        if (outA !== 64'd1) begin
            n_fail++;
            $display("FAIL const_a: outA=%h, want 1", outA);
        end
        idle_inputs();
        seloutA = 4'd3; seloutB = 4'd3;
        tick();
        n_checks++;
        if (outA !== 64'd1 || outB !== 64'd0) begin
            n_fail++;
            $display("FAIL hold: outA=%h outB=%h, want 1 0", outA, outB);
        end
    endtask

    task automatic test_clr_sweep();
        int n;
        n = 0;
        do_write(2, 64'h55, M_FULL);
        idle_inputs();
        clr = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_busy_rise: busy=%b, want 1", busy);
        end
        for (int k = 1; k <= 40; k++) begin
            idle_inputs();
            if (k == 4) begin
                wen = 1'b1; selwreg = 4'd9; inA = 64'h99;
            end
            if (k == 6) begin
                seloutA = 4'd2; enrregA = 1'b1;
            end
            if (k == 7) begin
                cnstA = 1'b1; enrregA = 1'b1;
            end
            if (k == 8) clr = 1'b1;
            tick();
            n = k;
            if (k == 6) begin
                n_checks++;
                if (outA !== 64'd0) begin
                    n_fail++;
                    $display("FAIL busy_read_zero: outA=%h, want 0", outA);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (outA !== 64'd1) begin
                    n_fail++;
                    $display("FAIL busy_read_const: outA=%h, want 1", outA);
                end
            end
            if (busy !== 1'b1) break;
        end
        n_checks++;
        if (n != NREGS) begin
            n_fail++;
            $display("FAIL clr_sweep_len: busy dropped after %0d edges, want %0d", n, NREGS);
        end
        do_read(2);
        n_checks++;
        if (outA !== 64'd0) begin
            n_fail++;
            $display("FAIL r2_cleared: outA=%h, want 0", outA);
        end
        do_read(9);
        n_checks++;
        if (outB !== 64'd0) begin
            n_fail++;
            $display("FAIL r9_write_ignored: outB=%h, want 0", outB);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        n = 0;
        do_write(3, 64'h1234, M_FULL);
        do_read(3);
        idle_inputs();
        clr = 1'b1;
        tick();
        idle_inputs();
        for (int k = 1; k <= 9; k++) tick();
        n_checks++;
        if (outA !== 64'h1234 || outB !== 64'h1234) begin
            n_fail++;
            $display("FAIL busy_hold: outA=%h outB=%h, want 1234", outA, outB);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (outA !== 64'd0 || outB !== 64'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: outA=%h outB=%h busy=%b, want 0 0 1", outA, outB, busy);
        end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n = k;
            if (busy !== 1'b1) break;
        end
        n_checks++;
        if (n != NREGS) begin
            n_fail++;
            $display("FAIL restart_sweep_len: busy dropped after %0d edges, want %0d", n, NREGS);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 149) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            wen     = $urandom_range(0, 1) == 1;
            selwreg = AW'($urandom_range(0, 3));
            wmode   = 2'($urandom_range(0, 3));
            inA     = {$urandom(), $urandom()};
            seloutA = AW'($urandom_range(0, 3));
            seloutB = AW'($urandom_range(0, 3));
            cnstA   = ($urandom_range(0, 7) == 0);
            cnstB   = ($urandom_range(0, 7) == 0);
            enrregA = ($urandom_range(0, 3) != 0);
            enrregB = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (outA !== m_outA || outB !== m_outB || busy !== (m_busy_cnt != 0)) begin
                n_fail++;
                $display("FAIL random_c%0d: outA=%h outB=%h busy=%b, want %h %h %b",
                         c, outA, outB, busy, m_outA, m_outB, (m_busy_cnt != 0));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sweep_after_reset();
        test_half_writes();
        test_accumulate();
        test_bypass();
        test_clr_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
